// File: rtl/wb_master_bridge.sv
// CPU-to-Wishbone master bridge with registered bus outputs, burst continuation,
// bounded retry with backoff and error reporting. Optional: WB_MASTER_TIMEOUT_EN.
module wb_master_bridge #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 24,
  parameter int SEL_W          = DATA_W / 8,
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_DELAY    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [SEL_W-1:0]  i_mem_sel,
  input  logic              i_mem_next,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_ack,
  output logic              o_mem_err,
  output logic              o_mem_busy,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_adr,
  output logic [DATA_W-1:0] o_wb_dat,
  output logic [SEL_W-1:0]  o_wb_sel,
  input  logic [DATA_W-1:0] i_wb_dat,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic              i_wb_rty
);

  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BD_W = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;

  generate
    if ((DATA_W % 8) != 0 || SEL_W != DATA_W / 8 || RETRY_DELAY < 1 ||
        MAX_RETRY < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("wb_master_bridge: invalid parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_BACKOFF
  } state_t;

  state_t            state, state_n;
  logic [RC_W-1:0]   rcnt, rcnt_n;
  logic [BD_W-1:0]   bcnt, bcnt_n;
  logic              cyc_n, stb_n, ack_n, err_n;
  logic [DATA_W-1:0] rdata_n;
  logic              load;
  logic              fail;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TC_W-1:0] tcnt, tcnt_n;
`endif

  assign o_mem_busy = (state != S_IDLE);

  always_comb begin
    state_n = state;
    cyc_n   = o_wb_cyc;
    stb_n   = o_wb_stb;
    rdata_n = o_mem_data;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    rcnt_n  = rcnt;
    bcnt_n  = bcnt;
    load    = 1'b0;
    fail    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_mem_req) begin
          load    = 1'b1;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          rcnt_n  = '0;
          state_n = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // err outranks ack outranks rty; an exhausted retry budget fails like err
        if (i_wb_err) begin
          fail = 1'b1;
        end else if (i_wb_ack) begin
          ack_n = 1'b1;
          if (!o_wb_we) rdata_n = i_wb_dat;
          if (i_mem_next) begin
            load   = 1'b1;
            rcnt_n = '0;
          end else begin
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            state_n = S_IDLE;
          end
        end else if (i_wb_rty) begin
          if (rcnt == RC_W'(MAX_RETRY)) begin
            fail = 1'b1;
          end else begin
            rcnt_n  = rcnt + RC_W'(1);
            stb_n   = 1'b0;
            bcnt_n  = BD_W'(RETRY_DELAY - 1);
            state_n = S_BACKOFF;
          end
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (tcnt == TC_W'(TIMEOUT_CYCLES)) begin
          fail = 1'b1;
        end
`endif
        if (fail) begin
          err_n   = 1'b1;
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_BACKOFF: begin
        if (bcnt == '0) begin
          stb_n   = 1'b1;
          state_n = S_ACTIVE;
        end else begin
          bcnt_n = bcnt - BD_W'(1);
        end
      end
      default: begin
        cyc_n   = 1'b0;
        stb_n   = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

`ifdef WB_MASTER_TIMEOUT_EN
  // Any exit from ACTIVE, or a new burst beat, restarts the wait count.
  always_comb begin
    tcnt_n = '0;
    if (state == S_ACTIVE && state_n == S_ACTIVE && !load) tcnt_n = tcnt + TC_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) tcnt <= '0;
    else          tcnt <= tcnt_n;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      rcnt       <= '0;
      bcnt       <= '0;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_adr   <= '0;
      o_wb_dat   <= '0;
      o_wb_sel   <= '0;
      o_mem_data <= '0;
      o_mem_ack  <= 1'b0;
      o_mem_err  <= 1'b0;
    end else begin
      state      <= state_n;
      rcnt       <= rcnt_n;
      bcnt       <= bcnt_n;
      o_wb_cyc   <= cyc_n;
      o_wb_stb   <= stb_n;
      o_mem_data <= rdata_n;
      o_mem_ack  <= ack_n;
      o_mem_err  <= err_n;
      if (load) begin
        o_wb_we  <= i_mem_we;
        o_wb_adr <= i_mem_addr;
        o_wb_dat <= i_mem_data;
        o_wb_sel <= i_mem_sel;
      end
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: scripted slave, queued expected CPU
// responses checked by an independent monitor, plus per-cycle bus traces.
module tb_wb_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_next;
  logic [23:0] mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  mem_sel;
  logic [15:0] mem_rdata;
  logic        mem_ack, mem_err, mem_busy;
  logic        wb_cyc, wb_stb, wb_we;
  logic [23:0] wb_adr;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel;
  logic [15:0] wb_dat_i;
  logic        wb_ack, wb_err, wb_rty;

  int total = 0;
  int bad   = 0;

  typedef struct {logic ack; logic err; logic rty; logic [15:0] dat;} rsp_t;
  typedef struct {logic is_err; logic [15:0] dat;} exp_t;
  typedef struct {logic cyc; logic stb; logic we; logic [23:0] adr; logic [15:0] dat;
                  logic ack; logic err; logic busy;} tr_t;

  rsp_t rsp_q[$];
  exp_t sb_q[$];
  tr_t  trace[$];
  logic [23:0] b_adr[4];
  logic [15:0] b_dat[4];

  wb_master_bridge #(
    .DATA_W(16), .ADDR_W(24), .SEL_W(2), .MAX_RETRY(3), .RETRY_DELAY(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_data(mem_data),
    .i_mem_sel(mem_sel), .i_mem_next(mem_next),
    .o_mem_data(mem_rdata), .o_mem_ack(mem_ack), .o_mem_err(mem_err), .o_mem_busy(mem_busy),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_adr(wb_adr),
    .o_wb_dat(wb_dat_o), .o_wb_sel(wb_sel),
    .i_wb_dat(wb_dat_i), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_rty(wb_rty)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: answers each stb cycle with the next scripted response, else stays silent.
  initial begin
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_dat_i = '0;
    forever begin
      rsp_t r;
      @(negedge clk);
      wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
      if (wb_stb && rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        wb_ack = r.ack; wb_err = r.err; wb_rty = r.rty; wb_dat_i = r.dat;
      end
    end
  end

  // Monitor: every CPU-side ack/err pulse consumes one expected entry.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && (mem_ack || mem_err)) begin
      chk("ack_err_exclusive", {31'd0, mem_ack & mem_err}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_kind", {31'd0, mem_err}, {31'd0, e.is_err});
        if (!e.is_err) chk("rsp_data", {16'd0, mem_rdata}, {16'd0, e.dat});
      end
    end
  end

  task automatic expect_rsp(input logic is_err, input logic [15:0] dat);
    sb_q.push_back('{is_err: is_err, dat: dat});
  endtask

  task automatic slave_rsp(input logic a, input logic e, input logic r, input logic [15:0] d);
    rsp_q.push_back('{ack: a, err: e, rty: r, dat: d});
  endtask

  // Issues a burst of nb beats and records one trace entry per cycle until idle.
  task automatic run_txn(input int nb, input logic we);
    int  k = 0;
    bit  done = 0;
    trace.delete();
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_addr = b_adr[0]; mem_data = b_dat[0];
    mem_sel = 2'b11; mem_next = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk); #1;
      trace.push_back('{cyc: wb_cyc, stb: wb_stb, we: wb_we, adr: wb_adr, dat: wb_dat_o,
                        ack: mem_ack, err: mem_err, busy: mem_busy});
      mem_req = 1'b0;
      if (!mem_busy) done = 1;
      if (mem_ack) k++;
      if (k + 1 < nb) begin
        mem_addr = b_adr[k+1]; mem_data = b_dat[k+1]; mem_next = 1'b1;
      end else begin
        mem_addr = '0; mem_data = '0; mem_next = 1'b0;
      end
    end
    chk("txn_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [7:0] stb_pat, cyc_pat;
    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_next = 1'b0;
    mem_addr = '0; mem_data = '0; mem_sel = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cyc",  {31'd0, wb_cyc}, 32'd0);
    chk("rst_stb",  {31'd0, wb_stb}, 32'd0);
    chk("rst_busy", {31'd0, mem_busy}, 32'd0);
    chk("rst_ack_err", {30'd0, mem_ack, mem_err}, 32'd0);
    chk("rst_adr",  {8'd0, wb_adr}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Single read, zero wait states
    b_adr[0] = 24'h000100; b_dat[0] = '0;
    slave_rsp(1, 0, 0, 16'hBEEF);
    expect_rsp(0, 16'hBEEF);
    run_txn(1, 1'b0);
    chk("rd_len",     trace.size(), 2);
    chk("rd_stb_n1",  {31'd0, trace[0].stb}, 32'd1);
    chk("rd_adr",     {8'd0, trace[0].adr}, 32'h100);
    chk("rd_ack_n2",  {31'd0, trace[1].ack}, 32'd1);
    chk("rd_cyc_n2",  {31'd0, trace[1].cyc}, 32'd0);

    // Write burst of three, read data register must hold
    b_adr[0] = 24'h10; b_adr[1] = 24'h11; b_adr[2] = 24'h12;
    b_dat[0] = 16'hA001; b_dat[1] = 16'hA002; b_dat[2] = 16'hA003;
    repeat (3) slave_rsp(1, 0, 0, 16'h0000);
    repeat (3) expect_rsp(0, 16'hBEEF);
    run_txn(3, 1'b1);
    chk("wb_len", trace.size(), 4);
    for (int i = 0; i < 3; i++) begin
      chk("wb_cyc_cont", {30'd0, trace[i].cyc, trace[i].stb}, 32'd3);
      chk("wb_adr_seq",  {8'd0, trace[i].adr}, 32'h10 + i);
    end
    chk("wb_we",     {31'd0, trace[1].we}, 32'd1);
    chk("wb_dat_b1", {16'd0, trace[1].dat}, 32'hA002);
    chk("wb_cyc_end", {31'd0, trace[3].cyc}, 32'd0);

    // Two retries then ack
    b_adr[0] = 24'h000200;
    slave_rsp(0, 0, 1, 0); slave_rsp(0, 0, 1, 0); slave_rsp(1, 0, 0, 16'h1234);
    expect_rsp(0, 16'h1234);
    run_txn(1, 1'b0);
    chk("rty_len", trace.size(), 8);
    stb_pat = '0; cyc_pat = '0;
    for (int i = 0; i < 8 && i < trace.size(); i++) begin
      stb_pat[7-i] = trace[i].stb;
      cyc_pat[7-i] = trace[i].cyc;
    end
    chk("rty_stb_pat", {24'd0, stb_pat}, 32'b1001_0010);
    chk("rty_cyc_pat", {24'd0, cyc_pat}, 32'b1111_1110);

    // Retry exhaustion: fourth rty reported as error
    b_adr[0] = 24'h000300;
    repeat (4) slave_rsp(0, 0, 1, 0);
    expect_rsp(1, 16'h0000);
    run_txn(1, 1'b0);
    chk("rtyx_len", trace.size(), 11);
    chk("rtyx_stb_last", {31'd0, trace[9].stb}, 32'd1);
    chk("rtyx_err_cyc", {30'd0, trace[10].err, trace[10].cyc}, 32'd2);

    // Error with simultaneous ack on beat 2 aborts the burst
    b_adr[0] = 24'h20; b_adr[1] = 24'h21; b_adr[2] = 24'h22;
    slave_rsp(1, 0, 0, 16'h5555); slave_rsp(1, 1, 0, 16'h6666);
    expect_rsp(0, 16'h5555); expect_rsp(1, 16'h0000);
    run_txn(3, 1'b0);
    chk("err_len", trace.size(), 3);
    chk("err_adr_b2", {8'd0, trace[1].adr}, 32'h21);
    chk("err_cyc", {31'd0, trace[2].cyc}, 32'd0);
    chk("err_data_hold", {16'd0, mem_rdata}, 32'h5555);

    // Asynchronous reset while stb is high
    @(negedge clk); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 24'h000400;
    @(negedge clk); mem_req = 1'b0;
    @(negedge clk); #1;
    chk("arst_pre_stb", {31'd0, wb_stb}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
    chk("arst_busy", {31'd0, mem_busy}, 32'd0);
    chk("arst_adr", {8'd0, wb_adr}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

`ifdef WB_MASTER_TIMEOUT_EN
    // Silent slave: error pulse nine cycles after stb rises
    b_adr[0] = 24'h000500;
    expect_rsp(1, 16'h0000);
    run_txn(1, 1'b0);
    chk("to_len", trace.size(), 10);
    chk("to_stb_before", {31'd0, trace[8].stb}, 32'd1);
    chk("to_err", {31'd0, trace[9].err}, 32'd1);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    chk("slave_drained", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Parametrised CPU-to-Wishbone master bridge. It generalises the fixed 16-bit CPU memory adapter to any data and address width.
- Adds fully registered Wishbone outputs, burst continuation, retry handling with backoff and a bounded retry count, and error reporting back to the CPU.
- Sits between a CPU memory port (fetch or load/store unit) and the Wishbone interconnect.

Parameters:
- DATA_W, 16, data bus width in bits; must be a multiple of 8.
- ADDR_W, 24, Wishbone address width in bits.
- SEL_W, DATA_W/8, byte-select width.
- MAX_RETRY, 3, number of rty responses tolerated per beat; the next rty is reported as an error. A value of 0 means the first rty is an error.
- RETRY_DELAY, 2, idle cycles between an rty response and re-asserting stb (minimum 1).
- TIMEOUT_CYCLES, 255, cycles without any response before a beat aborts (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_mem_req  in  1  CPU request; sampled only in IDLE
- i_mem_we  in  1  write enable
- i_mem_addr  in  ADDR_W  beat address
- i_mem_data  in  DATA_W  write data
- i_mem_sel  in  SEL_W  byte selects
- i_mem_next  in  1  burst continuation; sampled on the ack cycle
- o_mem_data  out  DATA_W  read data, registered
- o_mem_ack  out  1  one-cycle beat-complete pulse
- o_mem_err  out  1  one-cycle beat-failed pulse
- o_mem_busy  out  1  high in any state other than IDLE
- o_wb_cyc  out  1
- o_wb_stb  out  1
- o_wb_we  out  1
- o_wb_adr  out  ADDR_W
- o_wb_dat  out  DATA_W
- o_wb_sel  out  SEL_W
- i_wb_dat  in  DATA_W
- i_wb_ack  in  1
- i_wb_err  in  1
- i_wb_rty  in  1

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - All outputs go to 0 immediately and the state becomes IDLE.
  - A reset mid-cycle drops cyc/stb without a CPU ack or err.
  - Retry and timeout counters clear.
- States: IDLE, ACTIVE, BACKOFF.
- IDLE:
  - If i_mem_req=1 at edge N: latch addr/data/sel/we into the o_wb_* registers and enter ACTIVE.
  - cyc=stb=1 from cycle N+1. Retry counter clears.
- ACTIVE: cyc=stb=1 and the bus-side registers are held stable until a response. Response priority is err > ack > rty.
  - ack with i_mem_next=0: o_mem_data<=i_wb_dat (reads only; held otherwise), o_mem_ack=1 in the next cycle, cyc/stb=0 in the next cycle, go to IDLE.
  - ack with i_mem_next=1: same o_mem_data/o_mem_ack update. New addr/data/sel/we are latched from the CPU inputs in the same edge; stay ACTIVE with cyc=stb=1, no idle gap. Retry counter clears.
  - err: o_mem_err=1 in the next cycle, cyc/stb=0, go to IDLE. Any burst is aborted regardless of i_mem_next.
  - rty with count<MAX_RETRY: count+1, stb=0 with cyc kept 1, go to BACKOFF.
  - rty with count=MAX_RETRY: treated as err.
- BACKOFF:
  - Hold for RETRY_DELAY cycles with cyc=1, stb=0.
  - Then re-enter ACTIVE with stb=1 and the same latched beat.
- i_mem_req while busy is ignored. The CPU must hold i_mem_req low or stable; only IDLE samples it.
- Response inputs are ignored while stb=0.
- o_mem_ack and o_mem_err are never asserted together and each lasts exactly 1 cycle.
- Latency: single read without wait states gives req edge N, stb at N+1, slave ack at N+1, o_mem_ack at N+2.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of width ceil(log2(TIMEOUT_CYCLES+1)) counts cycles in ACTIVE without a response.
  - It clears on beat start, on every retry and on every burst beat.
  - On reaching TIMEOUT_CYCLES: cyc/stb=0, o_mem_err=1 in the next cycle, go to IDLE.
  - A response arriving on the same edge as the timeout takes priority.
- Not defined: no counter is built, TIMEOUT_CYCLES is unused, and the bridge waits indefinitely for a response.

Test Plan:
- Single read: req addr=0x000100, slave acks in 1st stb cycle with dat=0xBEEF -> o_mem_ack at N+2, o_mem_data=0xBEEF, cyc low at N+2.
- Write burst of 3: addrs 0x10/0x11/0x12, next=1,1,0, slave acks every cycle -> cyc high continuously for 3 cycles, o_wb_adr sequence 0x10,0x11,0x12, three o_mem_ack pulses.
- Retry: slave rty twice then ack, RETRY_DELAY=2 -> stb low for 2 cycles after each rty, cyc stays high, single o_mem_ack, no err.
- Retry exhaustion: MAX_RETRY=3, slave always rty -> 3 backoffs, then on the 4th rty an o_mem_err pulse, cyc low, no ack.
- Error mid-burst plus simultaneous err+ack: err on beat 2 with next=1 -> o_mem_err only, burst aborted, IDLE.
- Reset and timeout: i_rst_n low while stb high -> cyc/stb 0 immediately. With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8 and a silent slave -> o_mem_err 9 cycles after stb rises.
